// File: rtl/video_source_switch.sv
// Frame-synchronised N-channel video source selector with one-cycle registered output.
// Optional forced-switch timeout compiled in with VSS_TIMEOUT_EN.
module video_source_switch #(
    parameter int                DATA_W      = 16,
    parameter int                NUM_CH      = 4,
    parameter int                SEL_W       = $clog2(NUM_CH),
    parameter int                INIT_SEL    = 0,
    parameter logic [NUM_CH-1:0] BIN_MASK    = 4'b1000,
    parameter int                TIMEOUT_CYC = 1048576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic                     sel_load,
    input  logic                     bin_invert,
    input  logic [NUM_CH-1:0]        in_vsync,
    input  logic [NUM_CH-1:0]        in_hsync,
    input  logic [NUM_CH-1:0]        in_de,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_vsync,
    output logic                     out_hsync,
    output logic                     out_de,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     busy,
    output logic                     timeout_err
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_WAIT_VS = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   NUM_CH_W   = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] INIT_SEL_W = SEL_W'(INIT_SEL);

    function automatic logic [DATA_W-1:0] bin_expand(input logic bit0, input logic inv);
        bin_expand = inv ? {DATA_W{~bit0}} : {DATA_W{bit0}};
    endfunction

    state_t              r_state;
    state_t              w_state_nx;
    logic [SEL_W-1:0]    r_cur_sel;
    logic [SEL_W-1:0]    w_cur_sel_nx;
    logic [SEL_W-1:0]    r_target;
    logic [SEL_W-1:0]    w_target_nx;
    logic                r_busy;
    logic                w_busy_nx;
    logic                r_timeout_err;
    logic                w_timeout_err_nx;
    logic [NUM_CH-1:0]   r_vsync_d;
    logic [NUM_CH-1:0]   w_vs_rise;
    logic                w_load_ok;
    logic                w_switch;
    logic                w_force;
    logic [SEL_W-1:0]    w_src;
    logic                w_blank;
    logic [DATA_W-1:0]   w_px;
    logic                w_is_bin;
    logic                r_out_vsync;
    logic                r_out_hsync;
    logic                r_out_de;
    logic [DATA_W-1:0]   r_out_data;
    logic                w_out_vsync_nx;
    logic                w_out_hsync_nx;
    logic                w_out_de_nx;
    logic [DATA_W-1:0]   w_out_data_nx;

    assign w_vs_rise = in_vsync & ~r_vsync_d;
    assign w_load_ok = sel_load && ({1'b0, sel_req} < NUM_CH_W);

`ifdef VSS_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;

    // Any valid load while waiting either retargets or leaves WAIT_VS, so it always restarts the count.
    assign w_cnt_clr = (r_state != ST_WAIT_VS) || w_load_ok;
    assign w_force   = (r_state == ST_WAIT_VS) && (r_cnt == CNT_LAST);

    // Wait-for-vsync cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Control FSM next-state: switch completion is resolved before any same-cycle load
    always_comb begin
        w_state_nx       = r_state;
        w_cur_sel_nx     = r_cur_sel;
        w_target_nx      = r_target;
        w_busy_nx        = r_busy;
        w_timeout_err_nx = r_timeout_err;
        w_switch         = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_load_ok && (sel_req != r_cur_sel)) begin
                    w_target_nx      = sel_req;
                    w_state_nx       = ST_WAIT_VS;
                    w_busy_nx        = 1'b1;
                    w_timeout_err_nx = 1'b0;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_WAIT_VS: begin
                if (w_vs_rise[r_target] || w_force) begin
                    w_switch     = 1'b1;
                    w_cur_sel_nx = r_target;
                    w_state_nx   = ST_RUN;
                    w_busy_nx    = 1'b0;
                    if (w_force && !w_vs_rise[r_target]) begin
                        w_timeout_err_nx = 1'b1;
                    end else begin
                        w_timeout_err_nx = r_timeout_err;
                    end
                    if (w_load_ok && (sel_req != r_target)) begin
                        w_target_nx      = sel_req;
                        w_state_nx       = ST_WAIT_VS;
                        w_busy_nx        = 1'b1;
                        w_timeout_err_nx = 1'b0;
                    end else begin
                        w_target_nx = r_target;
                    end
                end else if (w_load_ok) begin
                    if (sel_req == r_cur_sel) begin
                        w_target_nx = r_cur_sel;
                        w_state_nx  = ST_RUN;
                        w_busy_nx   = 1'b0;
                    end else begin
                        w_target_nx = sel_req;
                    end
                end else begin
                    w_state_nx = ST_WAIT_VS;
                end
            end
            default: begin
                w_state_nx   = ST_RUN;
                w_cur_sel_nx = INIT_SEL_W;
                w_target_nx  = INIT_SEL_W;
                w_busy_nx    = 1'b0;
            end
        endcase
    end

    // Source channel mux; on the switch edge the target's sample is already taken
    always_comb begin
        w_src    = w_switch ? r_target : r_cur_sel;
        w_blank  = (r_state == ST_WAIT_VS) && !w_switch;
        w_px     = {DATA_W{1'b0}};
        w_is_bin = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_px     = (w_src == SEL_W'(c)) ? in_data[c*DATA_W +: DATA_W] : w_px;
            w_is_bin = (w_src == SEL_W'(c)) ? BIN_MASK[c] : w_is_bin;
        end
        w_out_vsync_nx = in_vsync[w_src];
        w_out_hsync_nx = in_hsync[w_src];
        if (w_blank) begin
            w_out_de_nx   = 1'b0;
            w_out_data_nx = {DATA_W{1'b0}};
        end else begin
            w_out_de_nx   = in_de[w_src];
            w_out_data_nx = w_is_bin ? bin_expand(w_px[0], bin_invert) : w_px;
        end
    end

    // Control state registers; vsync history resets high so no edge fires right after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_cur_sel     <= INIT_SEL_W;
            r_target      <= INIT_SEL_W;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_vsync_d     <= {NUM_CH{1'b1}};
        end else begin
            r_state       <= w_state_nx;
            r_cur_sel     <= w_cur_sel_nx;
            r_target      <= w_target_nx;
            r_busy        <= w_busy_nx;
            r_timeout_err <= w_timeout_err_nx;
            r_vsync_d     <= in_vsync;
        end
    end

    // Output pixel/sync registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vsync <= 1'b0;
            r_out_hsync <= 1'b0;
            r_out_de    <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
        end else begin
            r_out_vsync <= w_out_vsync_nx;
            r_out_hsync <= w_out_hsync_nx;
            r_out_de    <= w_out_de_nx;
            r_out_data  <= w_out_data_nx;
        end
    end

    assign out_vsync   = r_out_vsync;
    assign out_hsync   = r_out_hsync;
    assign out_de      = r_out_de;
    assign out_data    = r_out_data;
    assign cur_sel     = r_cur_sel;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_video_source_switch.sv
// Directed self-checking bench for video_source_switch (4-channel main instance, 3-channel instance for invalid selects).
module tb_video_source_switch;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel_req;
    logic        sel_load;
    logic        sel_load3;
    logic        bin_invert;
    logic [3:0]  vs;
    logic [3:0]  hs;
    logic [3:0]  de;
    logic [63:0] din;

    logic        out_vsync, out_hsync, out_de;
    logic [15:0] out_data;
    logic [1:0]  cur_sel;
    logic        busy, timeout_err;

    logic        o3_vsync, o3_hsync, o3_de;
    logic [15:0] o3_data;
    logic [1:0]  c3_sel;
    logic        b3_busy, t3_err;

    int n_cmp;
    int n_mis;

    video_source_switch #(
        .DATA_W(16), .NUM_CH(4), .SEL_W(2), .INIT_SEL(0),
        .BIN_MASK(4'b1000), .TIMEOUT_CYC(64)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_load(sel_load),
        .bin_invert(bin_invert), .in_vsync(vs), .in_hsync(hs), .in_de(de),
        .in_data(din), .out_vsync(out_vsync), .out_hsync(out_hsync),
        .out_de(out_de), .out_data(out_data), .cur_sel(cur_sel),
        .busy(busy), .timeout_err(timeout_err)
    );

    video_source_switch #(
        .DATA_W(16), .NUM_CH(3), .SEL_W(2), .INIT_SEL(0),
        .BIN_MASK(3'b000), .TIMEOUT_CYC(64)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_load(sel_load3),
        .bin_invert(bin_invert), .in_vsync(vs[2:0]), .in_hsync(hs[2:0]),
        .in_de(de[2:0]), .in_data(din[47:0]), .out_vsync(o3_vsync),
        .out_hsync(o3_hsync), .out_de(o3_de), .out_data(o3_data),
        .cur_sel(c3_sel), .busy(b3_busy), .timeout_err(t3_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic h, input logic e, input logic [15:0] px);
        vs[c] = v;
        hs[c] = h;
        de[c] = e;
        din[c*16 +: 16] = px;
    endtask

    task automatic load(input logic [1:0] s);
        sel_req  = s;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_req = 2'd0; sel_load = 1'b0; sel_load3 = 1'b0; bin_invert = 1'b0;
        vs = 4'hF; hs = 4'hF; de = 4'hF; din = 64'hFFFF_FFFF_FFFF_FFFF;
        #12;
        n_cmp++; if (out_data !== 16'h0000) begin n_mis++; $display("FAIL rst_data: got %h want %h", out_data, 16'h0000); end
        n_cmp++; if ({out_vsync, out_hsync, out_de} !== 3'b000) begin n_mis++; $display("FAIL rst_syncs: got %b want 000", {out_vsync, out_hsync, out_de}); end
        n_cmp++; if ({cur_sel, busy, timeout_err} !== 4'b0000) begin n_mis++; $display("FAIL rst_ctrl: got %b want 0000", {cur_sel, busy, timeout_err}); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if ({cur_sel, busy} !== 3'b000) begin n_mis++; $display("FAIL rst_first_cycle: got %b want 000", {cur_sel, busy}); end
        vs = 4'h0; hs = 4'h0; de = 4'h0; din = 64'h0;
        tick();
    endtask

    task automatic test_passthrough();
        set_ch(0, 1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        n_cmp++; if (out_data !== 16'h1234) begin n_mis++; $display("FAIL pass_data: got %h want %h", out_data, 16'h1234); end
        n_cmp++; if ({out_vsync, out_hsync, out_de} !== 3'b011) begin n_mis++; $display("FAIL pass_syncs: got %b want 011", {out_vsync, out_hsync, out_de}); end
        set_ch(0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        tick();
        n_cmp++; if ({out_vsync, out_data} !== {1'b1, 16'hBEEF}) begin n_mis++; $display("FAIL pass_data2: got %h want %h", {out_vsync, out_data}, {1'b1, 16'hBEEF}); end
        set_ch(0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        tick();
    endtask

    task automatic test_switch();
        set_ch(2, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        load(2'd2);
        n_cmp++; if ({busy, cur_sel} !== 3'b100) begin n_mis++; $display("FAIL sw_busy: got %b want 100", {busy, cur_sel}); end
        set_ch(0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        tick();
        n_cmp++; if ({out_de, out_data} !== 17'h0) begin n_mis++; $display("FAIL sw_blank: got %h want 0", {out_de, out_data}); end
        n_cmp++; if (out_hsync !== 1'b1) begin n_mis++; $display("FAIL sw_old_hsync: got %b want 1", out_hsync); end
        set_ch(2, 1'b1, 1'b0, 1'b1, 16'h0A0B);
        tick();
        n_cmp++; if ({busy, cur_sel} !== 3'b010) begin n_mis++; $display("FAIL sw_done: got %b want 010", {busy, cur_sel}); end
        n_cmp++; if ({out_vsync, out_de, out_data} !== {2'b11, 16'h0A0B}) begin n_mis++; $display("FAIL sw_first_px: got %h want %h", {out_vsync, out_de, out_data}, {2'b11, 16'h0A0B}); end
        set_ch(2, 1'b1, 1'b0, 1'b1, 16'h0C0D);
        tick();
        n_cmp++; if (out_data !== 16'h0C0D) begin n_mis++; $display("FAIL sw_next_px: got %h want %h", out_data, 16'h0C0D); end
    endtask

    task automatic test_binary();
        set_ch(3, 1'b0, 1'b0, 1'b1, 16'h0001);
        load(2'd3);
        tick();
        bin_invert = 1'b1;
        set_ch(3, 1'b1, 1'b0, 1'b1, 16'h0001);
        tick();
        n_cmp++; if ({cur_sel, out_de, out_data} !== {2'd3, 1'b1, 16'h0000}) begin n_mis++; $display("FAIL bin_inv_b1: got %h want %h", {cur_sel, out_de, out_data}, {2'd3, 1'b1, 16'h0000}); end
        set_ch(3, 1'b1, 1'b0, 1'b1, 16'hFFFE);
        tick();
        n_cmp++; if (out_data !== 16'hFFFF) begin n_mis++; $display("FAIL bin_inv_b0: got %h want %h", out_data, 16'hFFFF); end
        bin_invert = 1'b0;
        set_ch(3, 1'b1, 1'b0, 1'b1, 16'h0001);
        tick();
        n_cmp++; if (out_data !== 16'hFFFF) begin n_mis++; $display("FAIL bin_noinv_b1: got %h want %h", out_data, 16'hFFFF); end
        set_ch(3, 1'b1, 1'b0, 1'b1, 16'hABCC);
        tick();
        n_cmp++; if (out_data !== 16'h0000) begin n_mis++; $display("FAIL bin_noinv_b0: got %h want %h", out_data, 16'h0000); end
    endtask

    task automatic test_retarget();
        vs = 4'h0;
        set_ch(1, 1'b0, 1'b0, 1'b1, 16'h1111);
        load(2'd2);
        load(2'd1);
        n_cmp++; if ({busy, cur_sel} !== 3'b111) begin n_mis++; $display("FAIL rt_busy: got %b want 111", {busy, cur_sel}); end
        vs[2] = 1'b1;
        tick();
        n_cmp++; if ({busy, cur_sel, out_de} !== 4'b1110) begin n_mis++; $display("FAIL rt_old_vs_ignored: got %b want 1110", {busy, cur_sel, out_de}); end
        vs[1] = 1'b1;
        tick();
        n_cmp++; if ({busy, cur_sel, out_vsync, out_data} !== {3'b001, 1'b1, 16'h1111}) begin n_mis++; $display("FAIL rt_done: got %h want %h", {busy, cur_sel, out_vsync, out_data}, {3'b001, 1'b1, 16'h1111}); end
    endtask

    task automatic test_cancel();
        vs = 4'h0;
        load(2'd0);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL cx_busy: got %b want 1", busy); end
        load(2'd1);
        n_cmp++; if ({busy, cur_sel, out_de} !== 4'b0010) begin n_mis++; $display("FAIL cx_run: got %b want 0010", {busy, cur_sel, out_de}); end
        tick();
        n_cmp++; if ({out_de, out_data} !== {1'b1, 16'h1111}) begin n_mis++; $display("FAIL cx_resume: got %h want %h", {out_de, out_data}, {1'b1, 16'h1111}); end
    endtask

    task automatic test_back_to_back();
        load(2'd2);
        set_ch(2, 1'b1, 1'b0, 1'b1, 16'h2222);
        sel_req = 2'd0; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        n_cmp++; if ({busy, cur_sel, out_vsync, out_data} !== {3'b110, 1'b1, 16'h2222}) begin n_mis++; $display("FAIL b2b_switch_load: got %h want %h", {busy, cur_sel, out_vsync, out_data}, {3'b110, 1'b1, 16'h2222}); end
        set_ch(0, 1'b1, 1'b0, 1'b1, 16'h3333);
        tick();
        n_cmp++; if ({busy, cur_sel, out_data} !== {3'b000, 16'h3333}) begin n_mis++; $display("FAIL b2b_second: got %h want %h", {busy, cur_sel, out_data}, {3'b000, 16'h3333}); end
    endtask

    task automatic test_invalid();
        sel_req = 2'd3; sel_load3 = 1'b1;
        tick();
        sel_load3 = 1'b0;
        n_cmp++; if ({b3_busy, c3_sel, o3_data} !== {3'b000, 16'h3333}) begin n_mis++; $display("FAIL inv_ignored: got %h want %h", {b3_busy, c3_sel, o3_data}, {3'b000, 16'h3333}); end
        sel_req = 2'd2; sel_load3 = 1'b1;
        tick();
        n_cmp++; if (b3_busy !== 1'b1) begin n_mis++; $display("FAIL inv_valid_accepted: got %b want 1", b3_busy); end
        sel_req = 2'd0;
        tick();
        sel_load3 = 1'b0;
        n_cmp++; if (b3_busy !== 1'b0) begin n_mis++; $display("FAIL inv_cancel: got %b want 0", b3_busy); end
    endtask

    task automatic test_timeout();
        vs = 4'h0; hs = 4'hF;
        load(2'd3);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL to_enter: got %b want 1", busy); end
`ifdef VSS_TIMEOUT_EN
        repeat (63) tick();
        n_cmp++; if ({busy, cur_sel, timeout_err} !== 4'b1000) begin n_mis++; $display("FAIL to_pending: got %b want 1000", {busy, cur_sel, timeout_err}); end
        tick();
        n_cmp++; if ({busy, cur_sel, timeout_err} !== 4'b0111) begin n_mis++; $display("FAIL to_forced: got %b want 0111", {busy, cur_sel, timeout_err}); end
        load(2'd1);
        n_cmp++; if ({busy, timeout_err} !== 2'b10) begin n_mis++; $display("FAIL to_clear: got %b want 10", {busy, timeout_err}); end
`else
        repeat (70) tick();
        n_cmp++; if ({busy, cur_sel, timeout_err} !== 4'b1000) begin n_mis++; $display("FAIL to_wait_forever: got %b want 1000", {busy, cur_sel, timeout_err}); end
`endif
    endtask

    task automatic test_reset_busy();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, cur_sel, timeout_err} !== 4'b0000) begin n_mis++; $display("FAIL rb_ctrl: got %b want 0000", {busy, cur_sel, timeout_err}); end
        n_cmp++; if ({out_vsync, out_hsync, out_de, out_data} !== 19'h0) begin n_mis++; $display("FAIL rb_out: got %h want 0", {out_vsync, out_hsync, out_de, out_data}); end
        vs = 4'hF;
        #3 rst_n = 1'b1;
        tick();
        n_cmp++; if ({busy, cur_sel, out_vsync, out_de, out_data} !== {3'b000, 2'b11, 16'h3333}) begin n_mis++; $display("FAIL rb_release: got %h want %h", {busy, cur_sel, out_vsync, out_de, out_data}, {3'b000, 2'b11, 16'h3333}); end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_passthrough();
        test_switch();
        test_binary();
        test_retarget();
        test_cancel();
        test_back_to_back();
        test_invalid();
        test_timeout();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
